bank_ram_arbiter: RTL and testbench
===================================

Name: bank_ram_arbiter

Overview:
- Shares the 5-bank single-port bank RAM among NUM_REQ independent requesters (e.g. matrix-load, sampler, DMA).
- Each bank has its own round-robin arbiter, so requesters targeting different banks proceed in the same cycle.
- Tracks the fixed bank read latency (RAM cycle plus output register) and routes read data back to the issuing requester with a valid strobe.
- Sits between the compute/DMA engines and the bank RAM's slave ports.

Parameters:
- NUM_REQ, 3, number of requesters
- NUM_BANKS, 5, number of RAM banks
- ADDR_WIDTH, 10, word address width per bank
- DATA_WIDTH, 64, data width
- RD_LATENCY, 2, cycles from accepted read to bank_rdata valid

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  request present
- req_ready  out  NUM_REQ  request accepted this cycle
- req_bank  in  NUM_REQ*BANK_SEL_W  target bank
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data
- rsp_valid  out  NUM_REQ  read data valid
- rsp_data  out  NUM_REQ*DATA_WIDTH  read data
- err_oob  out  NUM_REQ  1-cycle pulse: request to bank >= NUM_BANKS
- bank_en  out  NUM_BANKS  bank enable
- bank_we  out  NUM_BANKS  bank write enable
- bank_addr  out  NUM_BANKS*ADDR_WIDTH  bank address
- bank_wdata  out  NUM_BANKS*DATA_WIDTH  bank write data
- bank_rdata  in  NUM_BANKS*DATA_WIDTH  bank read data (registered)

Behaviour:
Reset values:
- rst asserted (async) -> rsp_valid=0, err_oob=0, all read-tracking pipeline entries invalid.
- Every round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
- In-flight reads are dropped; no rsp_valid for them after reset release.

Arbitration (combinational, same cycle):
- Per bank b, candidates = requesters with req_valid=1 and req_bank=b.
- Priority order starts at (ptr_b+1) mod NUM_REQ.
- Winner gets req_ready=1; losers get req_ready=0 and must hold their request stable.
- ptr_b <= winner index only in cycles with a grant; otherwise ptr_b holds.

Bank drive:
- A handshake (valid & ready) drives bank_en[b]=1, bank_we/addr/wdata from the winner in that same cycle.
- No grant -> bank_en[b]=0, bank_we[b]=0; addr/wdata are don't-care (driven 0).

Out-of-range bank:
- req_bank >= NUM_BANKS -> req_ready=1, err_oob=1 for one cycle.
- No bank access and no response.

Read return:
- Each granted read pushes {valid, bank index} into that requester's RD_LATENCY-deep shift register.
- Exactly RD_LATENCY cycles after the handshake: rsp_valid=1, rsp_data=bank_rdata[bank].
- A requester issues at most one request per cycle, so responses never collide. Fully pipelined: back-to-back reads give back-to-back rsp_valid.
- rsp_data holds its last value when rsp_valid=0; consumers must not rely on it.

Writes: no response; the write occurs in the grant cycle.

Simultaneous events:
- Read and write to the same bank from different requesters: arbitration serialises them, and the order follows the grant order.
- Read-after-write to the same address in consecutive grants returns the new data.
- No backpressure on rsp: consumers must always accept.

Decomposition:
- Package bank_arb_pkg:
  - NUM_BANKS
  - BANK_SEL_W = $clog2(NUM_BANKS)
  - RD_LATENCY
  - typedef rd_track_t {logic valid; logic [BANK_SEL_W-1:0] bank;}
- Sub-module rr_arbiter:
  - parameter N
  - ports: clk, rst, req[N], gnt[N] one-hot
  - owns its pointer; one instance per bank.

Test Plan:
- Req0 writes bank2 addr 0x10 = 0xA5A5, then reads it back -> req_ready=1 both cycles; bank_en[2]=1; rsp_valid[0]=1 exactly 2 cycles after the read handshake; rsp_data[0]=0xA5A5.
- Req0/1/2 all read bank1 continuously for 6 cycles -> grants 0,1,2,0,1,2; each rsp_valid arrives 2 cycles after its own grant.
- Req0 reads bank0 while req1 reads bank4 in the same cycle -> both ready=1; both rsp_valid fire together with the correct per-bank data.
- Req2 with req_bank=6 -> ready=1, err_oob[2]=1 for one cycle; all bank_en stay 0; no rsp_valid[2].
- Reset asserted 1 cycle after a read handshake -> rsp_valid stays 0 through and after reset; the next request from req0 is granted first.
- Req1 reads bank3 at a fixed address for 8 back-to-back cycles after preloading data -> 8 consecutive rsp_valid[1] cycles with no gaps.

Source files
------------

// File: rtl/bank_arb_pkg.sv
// Shared constants and the read-tracking record for the bank RAM arbiter.
package bank_arb_pkg;

  localparam int unsigned NUM_BANKS  = 5;
  localparam int unsigned BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int unsigned RD_LATENCY = 2;

  typedef struct packed {
    logic                  valid;
    logic [BANK_SEL_W-1:0] bank;
  } rd_track_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the pointer remembers the last winner.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    // Search starts just after the previous winner.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bank_ram_arbiter.sv
// Per-bank round-robin access to the banked RAM with read-latency tracking and
// routing of read data back to the issuing requester. err_oob is registered.
module bank_ram_arbiter
  import bank_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*BANK_SEL_W-1:0]   req_bank,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_data,
  output logic [NUM_REQ-1:0]              err_oob,
  output logic [NUM_BANKS-1:0]            bank_en,
  output logic [NUM_BANKS-1:0]            bank_we,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata
);

  logic [BANK_SEL_W-1:0] sel   [NUM_REQ];
  logic [NUM_REQ-1:0]    oob;
  logic [NUM_REQ-1:0]    cand  [NUM_BANKS];
  logic [NUM_REQ-1:0]    gnt   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rdata [NUM_BANKS];
  rd_track_t             push  [NUM_REQ];
  rd_track_t             trk_q [NUM_REQ][RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_q [NUM_REQ];

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      sel[r] = req_bank[r*BANK_SEL_W +: BANK_SEL_W];
      oob[r] = req_valid[r] && (32'(sel[r]) >= NUM_BANKS);
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      rdata[b] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        cand[b][r] = req_valid[r] && !oob[r] && (32'(sel[r]) == b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(
      .N(NUM_REQ)
    ) u_arb (
      .clk(clk),
      .rst(rst),
      .req(cand[b]),
      .gnt(gnt[b])
    );
  end

  // Grant implies valid, so a grant is a handshake and drives the bank directly.
  always_comb begin
    req_ready  = oob;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      push[r] = '0;
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (gnt[b][r]) begin
          req_ready[r]                            = 1'b1;
          bank_en[b]                              = 1'b1;
          bank_we[b]                              = req_we[r];
          bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH]   = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
          bank_wdata[b*DATA_WIDTH +: DATA_WIDTH]  = req_wdata[r*DATA_WIDTH +: DATA_WIDTH];
          if (!req_we[r]) begin
            push[r].valid = 1'b1;
            push[r].bank  = BANK_SEL_W'(b);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_oob <= '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        data_q[r] <= '0;
        for (int unsigned s = 0; s < RD_LATENCY; s++) begin
          trk_q[r][s] <= '0;
        end
      end
    end else begin
      err_oob <= oob;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        trk_q[r][0] <= push[r];
        for (int unsigned s = 1; s < RD_LATENCY; s++) begin
          trk_q[r][s] <= trk_q[r][s-1];
        end
        if (trk_q[r][RD_LATENCY-1].valid) begin
          data_q[r] <= rdata[trk_q[r][RD_LATENCY-1].bank];
        end
      end
    end
  end

  // The tail entry lines up with the cycle bank_rdata carries its data.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      rsp_valid[r] = trk_q[r][RD_LATENCY-1].valid;
      rsp_data[r*DATA_WIDTH +: DATA_WIDTH] = trk_q[r][RD_LATENCY-1].valid ?
          rdata[trk_q[r][RD_LATENCY-1].bank] : data_q[r];
    end
  end

endmodule

// File: tb/tb_bank_ram_arbiter.sv
// Directed bench for bank_ram_arbiter with a behavioural two-stage bank RAM model.
module tb_bank_ram_arbiter;

  localparam int NR = 3;
  localparam int NB = 5;
  localparam int SW = 3;
  localparam int AW = 10;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*SW-1:0] req_bank;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [NR*DW-1:0] rsp_data;
  logic [NR-1:0]    err_oob;
  logic [NB-1:0]    bank_en;
  logic [NB-1:0]    bank_we;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata;
  logic [NB*DW-1:0] bank_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bank_ram_arbiter u_dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_bank(req_bank),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .err_oob(err_oob),
    .bank_en(bank_en),
    .bank_we(bank_we),
    .bank_addr(bank_addr),
    .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  // Bank RAM: array read on the enable edge, then an output register.
  logic [DW-1:0] mem [NB][1024];
  logic [DW-1:0] s1 [NB];
  logic [DW-1:0] s2 [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_wdata[b*DW +: DW];
        else            s1[b] <= mem[b][bank_addr[b*AW +: AW]];
      end
      s2[b] <= s1[b];
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = s2[b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int r, input int bank, input bit we, input int addr,
                         input logic [DW-1:0] wd);
    req_valid[r]         = 1'b1;
    req_we[r]            = we;
    req_bank[r*SW +: SW] = SW'(bank);
    req_addr[r*AW +: AW] = AW'(addr);
    req_wdata[r*DW +: DW] = wd;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    #1;
    check("reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset err_oob", 64'(err_oob), 64'h0);
    rst = 1'b0;
    step();

    // Write then read back bank2 addr 0x10 from req0.
    set_req(0, 2, 1'b1, 'h10, 64'hA5A5);
    #1;
    check("wr ready", 64'(req_ready), 64'h1);
    check("wr bank_en", 64'(bank_en), 64'h04);
    check("wr bank_we", 64'(bank_we), 64'h04);
    check("wr bank_addr", 64'(bank_addr[2*AW +: AW]), 64'h10);
    step();
    set_req(0, 2, 1'b0, 'h10, '0);
    #1;
    check("rd ready", 64'(req_ready), 64'h1);
    check("rd bank_we", 64'(bank_we), 64'h0);
    step();
    idle();
    #1;
    check("rd rsp early", 64'(rsp_valid), 64'h0);
    step();
    check("rd rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd rsp_data", rsp_data[0*DW +: DW], 64'hA5A5);
    step();
    check("rd rsp drop", 64'(rsp_valid), 64'h0);

    // Three-way contention on bank1.
    for (int c = 0; c < 8; c++) begin
      logic [NR-1:0] g_now, g_old;
      idle();
      if (c < 6) begin
        for (int r = 0; r < NR; r++) set_req(r, 1, 1'b0, r, '0);
      end
      #1;
      g_now = (c < 6) ? NR'(1 << (c % 3)) : '0;
      g_old = (c >= 2) ? NR'(1 << ((c - 2) % 3)) : '0;
      check($sformatf("rr ready c%0d", c), 64'(req_ready), 64'(g_now));
      check($sformatf("rr rsp c%0d", c), 64'(rsp_valid), 64'(g_old));
      step();
    end

    // Parallel banks: writes then reads on bank0 and bank4.
    idle();
    set_req(0, 0, 1'b1, 5, 64'h1111);
    set_req(1, 4, 1'b1, 7, 64'h4444);
    #1;
    check("par wr ready", 64'(req_ready), 64'h3);
    check("par wr en", 64'(bank_en), 64'h11);
    step();
    idle();
    set_req(0, 0, 1'b0, 5, '0);
    set_req(1, 4, 1'b0, 7, '0);
    #1;
    check("par rd ready", 64'(req_ready), 64'h3);
    step();
    idle();
    step();
    check("par rsp_valid", 64'(rsp_valid), 64'h3);
    check("par rsp0", rsp_data[0*DW +: DW], 64'h1111);
    check("par rsp1", rsp_data[1*DW +: DW], 64'h4444);
    step();

    // Out-of-range bank.
    set_req(2, 6, 1'b0, 0, '0);
    #1;
    check("oob ready", 64'(req_ready), 64'h4);
    check("oob bank_en", 64'(bank_en), 64'h0);
    step();
    idle();
    #1;
    check("oob err pulse", 64'(err_oob), 64'h4);
    step();
    check("oob err clear", 64'(err_oob), 64'h0);
    check("oob no rsp a", 64'(rsp_valid), 64'h0);
    step();
    check("oob no rsp b", 64'(rsp_valid), 64'h0);

    // Reset with a read in flight; bank1 pointer sits at req0 before reset.
    set_req(0, 1, 1'b0, 0, '0);
    #1;
    check("rst rd ready", 64'(req_ready), 64'h1);
    step();
    idle();
    rst = 1'b1;
    #1;
    check("rst rsp in", 64'(rsp_valid), 64'h0);
    step();
    check("rst rsp hold", 64'(rsp_valid), 64'h0);
    rst = 1'b0;
    step();
    check("rst rsp after", 64'(rsp_valid), 64'h0);
    set_req(0, 1, 1'b0, 0, '0);
    set_req(1, 1, 1'b0, 1, '0);
    #1;
    check("rst prio", 64'(req_ready), 64'h1);
    step();
    idle();
    step();
    check("rst new rsp", 64'(rsp_valid), 64'h1);
    step();

    // Back-to-back reads from req1 on bank3.
    set_req(1, 3, 1'b1, 'h3FF, 64'hDEAD_BEEF);
    step();
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 8) set_req(1, 3, 1'b0, 'h3FF, '0);
      #1;
      if (c < 8) check($sformatf("b2b ready c%0d", c), 64'(req_ready[1]), 64'h1);
      check($sformatf("b2b rsp c%0d", c), 64'(rsp_valid[1]), (c >= 2 && c <= 9) ? 64'h1 : 64'h0);
      if (c >= 2 && c <= 9) check($sformatf("b2b data c%0d", c), rsp_data[1*DW +: DW],
                                  64'hDEAD_BEEF);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
